// File: rtl/ir_assembler.sv
// Instruction register that assembles an NBYTES-wide instruction from byte-wide
// load strobes, big-endian, and publishes it atomically on the final byte.

module ir_byte_slot #(
  parameter int DATA_W = 8
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              clr_i,
  input  logic              wr_i,
  input  logic [DATA_W-1:0] data_i,
  output logic [DATA_W-1:0] q_o
);
  logic [DATA_W-1:0] q_q;

  always_ff @(posedge clk or posedge rst) begin
    if (rst)        q_q <= '0;
    else if (clr_i) q_q <= '0;
    else if (wr_i)  q_q <= data_i;
  end

  assign q_o = q_q;
endmodule

module ir_assembler #(
  parameter  int DATA_W = 8,
  parameter  int NBYTES = 2,
  parameter  int OPC_W  = 3,
  localparam int IDX_W  = (NBYTES > 1) ? $clog2(NBYTES) : 1
) (
  input  logic                       clk,
  input  logic                       rst,
  input  logic                       ena_i,
  input  logic                       load_i,
  input  logic                       clr_i,
  input  logic [DATA_W-1:0]          data_i,
  output logic [DATA_W*NBYTES-1:0]   instr_o,
  output logic [OPC_W-1:0]           opcode_o,
  output logic [DATA_W*NBYTES-OPC_W-1:0] operand_o,
  output logic [IDX_W-1:0]           byte_idx_o,
  output logic                       busy_o,
  output logic                       valid_o,
  output logic                       done_o
);
  localparam int INSTR_W = DATA_W * NBYTES;
  localparam logic [IDX_W-1:0] LAST_IDX = IDX_W'(NBYTES - 1);

  logic [IDX_W-1:0]   idx_q, idx_d;
  logic [INSTR_W-1:0] instr_q, instr_d;
  logic               valid_q, valid_d;
  logic               done_q, done_d;
  logic               accept, last;

  // asm_w is the instruction as it would look if the current byte completed it:
  // slot 0 is the live bus byte, upper slots come from the shadow buffer.
  logic [NBYTES-1:0][DATA_W-1:0] asm_w;

  assign accept = ena_i & load_i & ~clr_i;
  assign last   = (idx_q == LAST_IDX);

  for (genvar s = 0; s < NBYTES; s++) begin : g_slot
    if (s == 0) begin : g_live
      assign asm_w[0] = data_i;
    end else begin : g_shadow
      ir_byte_slot #(.DATA_W(DATA_W)) u_slot (
        .clk    (clk),
        .rst    (rst),
        .clr_i  (clr_i),
        .wr_i   (accept && (idx_q == IDX_W'(NBYTES - 1 - s))),
        .data_i (data_i),
        .q_o    (asm_w[s])
      );
    end
  end

  always_comb begin
    idx_d   = idx_q;
    instr_d = instr_q;
    valid_d = valid_q;
    done_d  = 1'b0;
    if (clr_i) begin
      idx_d   = '0;
      instr_d = '0;
      valid_d = 1'b0;
    end else if (accept) begin
      if (last) begin
        idx_d   = '0;
        instr_d = asm_w;
        valid_d = 1'b1;
        done_d  = 1'b1;
      end else begin
        idx_d = idx_q + IDX_W'(1);
      end
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      idx_q   <= '0;
      instr_q <= '0;
      valid_q <= 1'b0;
      done_q  <= 1'b0;
    end else begin
      idx_q   <= idx_d;
      instr_q <= instr_d;
      valid_q <= valid_d;
      done_q  <= done_d;
    end
  end

  assign instr_o    = instr_q;
  assign opcode_o   = instr_q[INSTR_W-1 -: OPC_W];
  assign operand_o  = instr_q[INSTR_W-OPC_W-1:0];
  assign byte_idx_o = idx_q;
  assign busy_o     = (idx_q != '0);
  assign valid_o    = valid_q;
  assign done_o     = done_q;
endmodule

// File: tb/tb_ir_assembler.sv
// Bench for ir_assembler: directed plus random stimulus against a byte-queue model,
// with extra instances for the NBYTES=3 and NBYTES=1 configurations.

module tb_ir_assembler;
  logic clk = 1'b0;
  logic rst = 1'b1;
  always #5 clk = ~clk;

  int checks = 0;
  int errors = 0;

  // main instance: DATA_W=8, NBYTES=2, OPC_W=3
  logic        ena_a = 0, load_a = 0, clr_a = 0;
  logic [7:0]  data_a = 0;
  logic [15:0] instr_a;
  logic [2:0]  opcode_a;
  logic [12:0] operand_a;
  logic [0:0]  idx_a;
  logic        busy_a, valid_a, done_a;

  ir_assembler #(.DATA_W(8), .NBYTES(2), .OPC_W(3)) dut_a (
    .clk(clk), .rst(rst), .ena_i(ena_a), .load_i(load_a), .clr_i(clr_a),
    .data_i(data_a), .instr_o(instr_a), .opcode_o(opcode_a), .operand_o(operand_a),
    .byte_idx_o(idx_a), .busy_o(busy_a), .valid_o(valid_a), .done_o(done_a));

  // NBYTES=3, OPC_W=4
  logic        ena_b = 0, load_b = 0, clr_b = 0;
  logic [7:0]  data_b = 0;
  logic [23:0] instr_b;
  logic [3:0]  opcode_b;
  logic [19:0] operand_b;
  logic [1:0]  idx_b;
  logic        busy_b, valid_b, done_b;

  ir_assembler #(.DATA_W(8), .NBYTES(3), .OPC_W(4)) dut_b (
    .clk(clk), .rst(rst), .ena_i(ena_b), .load_i(load_b), .clr_i(clr_b),
    .data_i(data_b), .instr_o(instr_b), .opcode_o(opcode_b), .operand_o(operand_b),
    .byte_idx_o(idx_b), .busy_o(busy_b), .valid_o(valid_b), .done_o(done_b));

  // NBYTES=1
  logic        ena_c = 0, load_c = 0, clr_c = 0;
  logic [7:0]  data_c = 0;
  logic [7:0]  instr_c;
  logic [2:0]  opcode_c;
  logic [4:0]  operand_c;
  logic [0:0]  idx_c;
  logic        busy_c, valid_c, done_c;

  ir_assembler #(.DATA_W(8), .NBYTES(1), .OPC_W(3)) dut_c (
    .clk(clk), .rst(rst), .ena_i(ena_c), .load_i(load_c), .clr_i(clr_c),
    .data_i(data_c), .instr_o(instr_c), .opcode_o(opcode_c), .operand_o(operand_c),
    .byte_idx_o(idx_c), .busy_o(busy_c), .valid_o(valid_c), .done_o(done_c));

  // reference model for dut_a: accepted bytes wait in a queue until NBYTES arrive
  localparam int NB = 2;
  logic [7:0]  m_q[$];
  logic [15:0] m_instr;
  logic        m_valid, m_done;

  task automatic model_reset();
    m_q.delete();
    m_instr = '0;
    m_valid = 1'b0;
    m_done  = 1'b0;
  endtask

  task automatic model_edge(input logic e, input logic l, input logic c, input logic [7:0] d);
    m_done = 1'b0;
    if (c) begin
      m_q.delete();
      m_instr = '0;
      m_valid = 1'b0;
    end else if (e && l) begin
      m_q.push_back(d);
      if (m_q.size() == NB) begin
        m_instr = '0;
        foreach (m_q[i]) m_instr = (m_instr << 8) | 16'(m_q[i]);
        m_valid = 1'b1;
        m_done  = 1'b1;
        m_q.delete();
      end
    end
  endtask

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic check_a(input string tag);
    chk({tag, ".instr"},   64'(instr_a),   64'(m_instr));
    chk({tag, ".opcode"},  64'(opcode_a),  64'(m_instr[15:13]));
    chk({tag, ".operand"}, 64'(operand_a), 64'(m_instr[12:0]));
    chk({tag, ".idx"},     64'(idx_a),     64'(m_q.size()));
    chk({tag, ".busy"},    64'(busy_a),    64'(m_q.size() != 0));
    chk({tag, ".valid"},   64'(valid_a),   64'(m_valid));
    chk({tag, ".done"},    64'(done_a),    64'(m_done));
  endtask

  // called at a negedge: drive, take one rising edge, check at the next negedge
  task automatic step_a(input string tag, input logic e, input logic l, input logic c,
                        input logic [7:0] d);
    ena_a = e; load_a = l; clr_a = c; data_a = d;
    @(posedge clk);
    model_edge(e, l, c, d);
    @(negedge clk);
    check_a(tag);
  endtask

  initial begin
    model_reset();
    // reset held for two cycles
    repeat (2) @(negedge clk);
    check_a("reset");
    chk("reset.b_instr", 64'(instr_b), 64'h0);
    chk("reset.c_done",  64'(done_c),  64'h0);
    rst = 1'b0;

    // basic fetch
    step_a("basic0", 1, 1, 0, 8'hA5);
    step_a("basic1", 1, 1, 0, 8'h3C);
    chk("basic.instr_const", 64'(instr_a), 64'hA53C);
    step_a("basic_idle", 1, 0, 0, 8'h00);

    // asynchronous reset pulse between edges
    #1 rst = 1'b1;
    #1 model_reset();
    check_a("async_rst");
    #1 rst = 1'b0;
    @(negedge clk);
    step_a("refill0", 1, 1, 0, 8'hA5);
    step_a("refill1", 1, 1, 0, 8'h3C);

    // gap between bytes: partial fetch held, old instruction stable
    step_a("gap_b0", 1, 1, 0, 8'h55);
    for (int i = 0; i < 3; i++) step_a("gap_hold", 1, 0, 0, 8'hFF);
    step_a("gap_b1", 1, 1, 0, 8'hAA);
    chk("gap.instr_const", 64'(instr_a), 64'h55AA);
    step_a("gap_after", 1, 0, 0, 8'h00);

    // enable low: everything holds
    step_a("ena0_a", 0, 1, 0, 8'hCC);
    step_a("ena0_b", 0, 1, 0, 8'hCC);

    // clear aborts a fetch and drops the coincident byte
    step_a("clr_start", 1, 1, 0, 8'h12);
    step_a("clr_hit",   1, 1, 1, 8'h34);
    chk("clr.instr_const", 64'(instr_a), 64'h0);
    step_a("clr_next0", 1, 1, 0, 8'h56);
    step_a("clr_next1", 1, 1, 0, 8'h78);

    // streaming, load held high
    step_a("stream0", 1, 1, 0, 8'h01);
    step_a("stream1", 1, 1, 0, 8'h02);
    step_a("stream2", 1, 1, 0, 8'h03);
    step_a("stream3", 1, 1, 0, 8'h04);
    step_a("stream_end", 1, 0, 0, 8'h00);

    // reset mid-fetch discards the partial byte
    step_a("mid_b0", 1, 1, 0, 8'h9A);
    rst = 1'b1;
    #1 model_reset();
    check_a("mid_rst");
    @(negedge clk);
    rst = 1'b0;
    step_a("mid_n0", 1, 1, 0, 8'hBC);
    step_a("mid_n1", 1, 1, 0, 8'hDE);

    // random traffic
    for (int i = 0; i < 300; i++) begin
      logic e, l, c;
      e = ($urandom_range(0, 9) != 0);
      l = ($urandom_range(0, 9) < 6);
      c = ($urandom_range(0, 19) == 0);
      step_a("rand", e, l, c, 8'($urandom));
    end

    // NBYTES=3, OPC_W=4
    ena_b = 1; load_b = 1;
    data_b = 8'hDE; @(negedge clk);
    chk("b.idx1", 64'(idx_b), 64'd1);
    chk("b.busy1", 64'(busy_b), 64'd1);
    data_b = 8'hAD; @(negedge clk);
    chk("b.idx2", 64'(idx_b), 64'd2);
    chk("b.instr_hold", 64'(instr_b), 64'h0);
    data_b = 8'hBE; @(negedge clk);
    load_b = 0;
    chk("b.instr",   64'(instr_b),   64'hDEADBE);
    chk("b.opcode",  64'(opcode_b),  64'hD);
    chk("b.operand", 64'(operand_b), 64'hEADBE);
    chk("b.idx0",    64'(idx_b),     64'd0);
    chk("b.valid",   64'(valid_b),   64'd1);
    chk("b.done",    64'(done_b),    64'd1);
    @(negedge clk);
    chk("b.done_drop", 64'(done_b), 64'd0);

    // NBYTES=1: every byte completes
    ena_c = 1;
    for (int i = 0; i < 6; i++) begin
      logic [7:0] d;
      d = 8'($urandom);
      load_c = 1; data_c = d;
      @(negedge clk);
      load_c = 0;
      chk("c.instr",   64'(instr_c),   64'(d));
      chk("c.opcode",  64'(opcode_c),  64'(d[7:5]));
      chk("c.operand", 64'(operand_c), 64'(d[4:0]));
      chk("c.done",    64'(done_c),    64'd1);
      chk("c.busy",    64'(busy_c),    64'd0);
      chk("c.idx",     64'(idx_c),     64'd0);
      @(negedge clk);
      chk("c.done_drop", 64'(done_c),  64'd0);
      chk("c.hold",      64'(instr_c), 64'(d));
    end

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end
endmodule

// File: doc/ir_assembler.md
Name: ir_assembler

Overview:
Parametrised instruction register for the 8-bit RISC CPU. It assembles a multi-byte instruction from the byte-wide data bus over successive load strobes, then presents the complete instruction atomically. Opcode and operand fields are split out for the controller. It sits between the memory data bus and the decode/controller, and replaces the single-byte load register.

Parameters:
DATA_W, 8, width of the data bus and of each instruction byte
NBYTES, 2, bytes per instruction; legal range 1..8
OPC_W, 3, opcode width taken from the MSBs of the instruction; must satisfy 1 <= OPC_W < DATA_W*NBYTES
IDX_W, derived (clog2(NBYTES), minimum 1), width of byte_idx

Ports:
clk  in  1  system clock, rising edge active
rst  in  1  asynchronous reset, active-high
ena  in  1  block enable; when low, load is ignored
load  in  1  byte strobe: capture data on this rising edge
clr  in  1  synchronous clear; aborts any fetch in progress
data  in  DATA_W  byte from the memory data bus
instr  out  DATA_W*NBYTES  last complete instruction
opcode  out  OPC_W  instr[MSB -: OPC_W]
operand  out  DATA_W*NBYTES-OPC_W  remaining low bits of instr
byte_idx  out  IDX_W  index of the next byte expected (0 = first byte)
busy  out  1  high while a fetch is partially assembled (byte_idx != 0)
valid  out  1  instr holds a complete instruction
done  out  1  one-cycle pulse in the cycle after the final byte is captured

Behaviour:
- Reset: clk and rst are the only clock and reset. Reset is asynchronous and active-high.
  - While rst is high, all outputs are 0 immediately: instr, opcode, operand, byte_idx, busy, valid, done.
  - The internal shadow buffer is also cleared.
- Accept condition: a byte is accepted on a rising clk edge when ena=1, load=1 and clr=0.
- Byte ordering is big-endian. The byte accepted at byte_idx=k is written to shadow byte slot NBYTES-1-k, so the first byte lands in the MSBs.
- Index advance: byte_idx increments on each accepted byte. When the accepted byte is at k=NBYTES-1, byte_idx wraps to 0.
- Completion (same edge as the final byte):
  - instr <= {shadow upper bytes, data}.
  - valid <= 1; done <= 1 for exactly one cycle.
  - Latency: instr is updated in the cycle after the final byte is captured, with no extra stage.
- Atomic update:
  - instr, opcode and operand change only on completion, on clr or on reset.
  - A partial fetch never shows on instr.
  - A previously valid instruction stays stable, with valid=1, while the next one is being assembled (busy=1).
- Gaps: load may drop between bytes for any number of cycles. The shadow buffer and byte_idx hold through the gap, and there is no timeout.
- ena=0: all state holds. done deasserts after its single cycle regardless of ena.
- clr (synchronous):
  - Has priority over load in the same cycle; the byte is dropped.
  - Sets byte_idx=0, shadow=0, instr=0, valid=0, done=0.
- NBYTES=1: every accepted byte completes an instruction. done pulses for each, busy is always 0, byte_idx is always 0.
- Back-to-back: load held high for 2*NBYTES cycles yields two completions, with done high on cycles NBYTES+1 and 2*NBYTES+1 after the first edge.
- Reset mid-fetch: the partial shadow is discarded. The next accepted byte is treated as byte 0.
- opcode and operand are pure slices of instr and carry no additional register stage.

Test Plan:
(defaults DATA_W=8, NBYTES=2, OPC_W=3; stimulus is driven on negedge)
1. Reset: rst=1 for 2 cycles -> all outputs 0. Pulse rst between clock edges with instr non-zero -> outputs 0 before the next posedge.
2. Basic fetch: ena=1, load=1 with data=A5 then data=3C on consecutive cycles -> after the 2nd posedge: instr=16'hA53C, opcode=3'b101, operand=13'h053C, valid=1, done high for one cycle. byte_idx sequence is 0,1,0.
3. Gap and hold: with instr=A53C and valid=1, load 55, then load=0 for 3 cycles, then load AA -> during the gap: busy=1, byte_idx=1, instr remains A53C, valid=1. After AA: instr=55AA, done pulses once.
4. Enable and clear:
   - ena=0, load=1, data=CC for 2 cycles -> no state change.
   - Start a fetch with 12, then assert clr together with load and data=34 -> byte_idx=0, busy=0, valid=0, instr=0, and 34 is not captured.
5. Streaming: load held high with data 01,02,03,04 -> instr=0102 then 0304, done high on the 2 completion cycles only.
6. Parameter sweep:
   - NBYTES=3, OPC_W=4, bytes DE,AD,BE -> instr=24'hDEADBE, opcode=4'hD, operand=20'hEADBE.
   - NBYTES=1 -> each byte yields done and instr=data.
